// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control slice.
// Contents:
//   REG_ADDR_W   - register-file address width
//   div_state_t  - divide occupancy FSM states (IDLE, BUSY, DONE)
//   strobe_t     - write-enable / flush bundle for PC and the four pipeline registers
//   STROBE_NONE / STROBE_DEFAULT - all-off and no-hazard strobe bundles
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

  localparam strobe_t STROBE_DEFAULT = '{
    pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1, memwb_we: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0
  };

endpackage

// File: rtl/div_stall_fsm.sv
// Divide occupancy tracker for the EX stage.
// Parameters:
//   DIV_CYCLES     - extra EX cycles a divide needs (>= 1)
// Ports:
//   clk            - clock, all state on rising edge
//   rst_n          - synchronous active-low reset
//   ex_div_start   - instruction in EX is a divide
//   mem_stall_req  - data memory not ready
//   div_busy       - divide is holding EX this cycle (combinational)
//   state          - current FSM state
module div_stall_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_div_start,
  input  logic       mem_stall_req,
  output logic       div_busy,
  output div_state_t state
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  // The start cycle itself is one busy cycle, so BUSY covers DIV_CYCLES more.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // A stalled memory stage keeps the divide from being accepted yet.
        if (ex_div_start && !mem_stall_req) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        // The divider keeps working even while memory stalls the pipe.
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        // Result is ready; leave only once the divide can actually advance.
        if (!mem_stall_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign div_busy = rst_n && (((state_reg == IDLE) && ex_div_start) || (state_reg == BUSY));
  assign state    = state_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and control unit: write-enable and flush strobes for the PC
// and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Priority (highest first): memory stall, divide busy, taken branch, load-use.
// Optional macro HAZARD_PERF_EN builds the stall_cycles / flush_count
// counters; without it both outputs are tied to zero.
// Parameters:
//   DIV_CYCLES - extra EX occupancy cycles of a divide (>= 1)
// Ports:
//   Clk, Rst_n                    - clock, synchronous active-low reset
//   id_rs1/2, id_rs1/2_used       - sources of the instruction in ID
//   ex_rd, ex_mem_read            - destination / load flag of EX instruction
//   ex_branch_taken, ex_div_start - EX redirect and divide indications
//   mem_stall_req                 - data memory not ready
//   *_we, *_flush                 - pipeline register strobes
//   div_busy                      - divide occupying EX
//   stall_cycles, flush_count     - performance counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_div_start,
  input  logic                  mem_stall_req,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  div_busy,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  div_state_t div_state;
  strobe_t    strobe;
  logic       load_use;

  // Once a divide has been accepted, the start flag is just the same
  // instruction sitting frozen in EX, so only IDLE may see it.
  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_fsm (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .ex_div_start (ex_div_start && (div_state == IDLE)),
    .mem_stall_req(mem_stall_req),
    .div_busy     (div_busy),
    .state        (div_state)
  );

  // x0 is hardwired, so a load into it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    strobe = STROBE_DEFAULT;
    if (!Rst_n) begin
      strobe = STROBE_NONE;
    end else if (mem_stall_req) begin
      // Freeze everything up to MEM; WB receives a bubble.
      strobe.pc_we       = 1'b0;
      strobe.ifid_we     = 1'b0;
      strobe.idex_we     = 1'b0;
      strobe.exmem_we    = 1'b0;
      strobe.memwb_flush = 1'b1;
    end else if (div_busy) begin
      // Freeze the front end and EX; MEM receives a bubble.
      strobe.pc_we       = 1'b0;
      strobe.ifid_we     = 1'b0;
      strobe.idex_we     = 1'b0;
      strobe.exmem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Wrong-path IF and ID instructions are discarded, which also
      // makes any load-use match in ID irrelevant.
      strobe.ifid_flush = 1'b1;
      strobe.idex_flush = 1'b1;
    end else if (load_use) begin
      strobe.pc_we      = 1'b0;
      strobe.ifid_we    = 1'b0;
      strobe.idex_flush = 1'b1;
    end
  end

  assign pc_we       = strobe.pc_we;
  assign ifid_we     = strobe.ifid_we;
  assign idex_we     = strobe.idex_we;
  assign exmem_we    = strobe.exmem_we;
  assign memwb_we    = strobe.memwb_we;
  assign ifid_flush  = strobe.ifid_flush;
  assign idex_flush  = strobe.idex_flush;
  assign exmem_flush = strobe.exmem_flush;
  assign memwb_flush = strobe.memwb_flush;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (!strobe.pc_we) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (strobe.ifid_flush || strobe.idex_flush || strobe.exmem_flush || strobe.memwb_flush) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with DIV_CYCLES = 4.
// Each step drives one cycle of stimulus, pushes the expected strobes and
// div_busy onto a scoreboard queue, then pops and compares on the falling edge.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DIV_CYCLES = 4;
`ifdef HAZARD_PERF_EN
  localparam logic [31:0] EXP_PERF = 32'd5;
`else
  localparam logic [31:0] EXP_PERF = 32'd0;
`endif

  // Strobe ordering: {pc, ifid, idex, exmem, memwb we, ifid, idex, exmem, memwb flush}
  localparam logic [8:0] S_RESET   = 9'b00000_0000;
  localparam logic [8:0] S_DEFAULT = 9'b11111_0000;
  localparam logic [8:0] S_MEM     = 9'b00001_0001;
  localparam logic [8:0] S_DIV     = 9'b00011_0010;
  localparam logic [8:0] S_BRANCH  = 9'b11111_1100;
  localparam logic [8:0] S_LOADUSE = 9'b00111_0100;

  logic                  Clk = 1'b0;
  logic                  Rst_n = 1'b0;
  logic [REG_ADDR_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic                  id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic                  ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic                  ex_div_start = 1'b0, mem_stall_req = 1'b0;
  logic                  pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic                  ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic                  div_busy;
  logic [31:0]           stall_cycles, flush_count;

  always #5 Clk = ~Clk;

  hazard_ctrl #(
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_div_start   (ex_div_start),
    .mem_stall_req  (mem_stall_req),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .idex_we        (idex_we),
    .exmem_we       (exmem_we),
    .memwb_we       (memwb_we),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .memwb_flush    (memwb_flush),
    .div_busy       (div_busy),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  typedef struct {
    string      tag;
    logic [8:0] strb;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected strobes from the priority rules; busy comes from the scenario.
  function automatic logic [8:0] ref_strobes(input logic rst_n, input logic stall,
                                             input logic busy, input logic br,
                                             input logic lu);
    if (!rst_n) return S_RESET;
    if (stall)  return S_MEM;
    if (busy)   return S_DIV;
    if (br)     return S_BRANCH;
    if (lu)     return S_LOADUSE;
    return S_DEFAULT;
  endfunction

  task automatic step(input string tag, input logic rst, input logic stall,
                      input logic start, input logic br, input logic mr,
                      input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs1,
                      input logic u1, input logic [REG_ADDR_W-1:0] rs2, input logic u2,
                      input logic exp_busy);
    exp_t       e;
    logic       lu;
    logic [8:0] obs;
    @(posedge Clk);
    #1;
    Rst_n           = rst;
    mem_stall_req   = stall;
    ex_div_start    = start;
    ex_branch_taken = br;
    ex_mem_read     = mr;
    ex_rd           = rd;
    id_rs1          = rs1;
    id_rs1_used     = u1;
    id_rs2          = rs2;
    id_rs2_used     = u2;
    lu = mr && (rd != '0) && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
    e.tag  = tag;
    e.strb = ref_strobes(rst, stall, exp_busy, br, lu);
    e.busy = rst && exp_busy;
    sb_q.push_back(e);
    @(negedge Clk);
    e = sb_q.pop_front();
    obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush};
    check({e.tag, ".strb"}, 32'(obs), 32'(e.strb));
    check({e.tag, ".busy"}, 32'(div_busy), 32'(e.busy));
  endtask

  // Shorthand for a quiet cycle apart from the divide/memory controls.
  task automatic dstep(input string tag, input logic stall, input logic start,
                       input logic br, input logic exp_busy);
    step(tag, 1'b1, stall, start, br, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a divide request present
    for (int i = 0; i < 3; i++)
      step($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dstep("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_flush_count", flush_count, 32'd0);

    // Load-use hazards
    step("lu_rs2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
    step("lu_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
    step("lu_rd0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    step("lu_unused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd2, 1'b1, 1'b0);
    step("lu_rs1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0);
    step("lu_nomatch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0);

    // Taken branch beats load-use
    step("br_lu", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    dstep("br_plain", 1'b0, 1'b0, 1'b1, 1'b0);

    // Divide pulse from a clean reset so the counters cover only this scenario
    step("div_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dstep("divp_start", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DIV_CYCLES; i++)
      dstep($sformatf("divp_busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    dstep("divp_done", 1'b0, 1'b0, 1'b0, 1'b0);
    dstep("divp_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("perf_stall_cycles", stall_cycles, EXP_PERF);
    check("perf_flush_count", flush_count, EXP_PERF);

    // Divide with start held (frozen in EX); branch ignored while busy
    dstep("divh_start", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("divh_busy0", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("divh_busy_br", 1'b0, 1'b1, 1'b1, 1'b1);
    dstep("divh_busy2", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("divh_busy3", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("divh_done", 1'b0, 1'b1, 1'b0, 1'b0);
    dstep("divh_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Memory stall inside BUSY keeps counting; stall held through DONE holds DONE
    dstep("divm_start", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      dstep($sformatf("divm_stall%0d", i), 1'b1, 1'b1, 1'b0, 1'b1);
    dstep("divm_busy_last", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("divm_done_st0", 1'b1, 1'b1, 1'b0, 1'b0);
    dstep("divm_done_st1", 1'b1, 1'b1, 1'b0, 1'b0);
    dstep("divm_done_rel", 1'b0, 1'b1, 1'b0, 1'b0);
    dstep("divm_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-BUSY aborts straight to IDLE (a new start is seen immediately)
    dstep("diva_start", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("diva_busy", 1'b0, 1'b0, 1'b0, 1'b1);
    step("diva_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dstep("diva_restart", 1'b0, 1'b1, 1'b0, 1'b1);
    dstep("diva_busy_again", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
